queue32: RTL
============

QUEUE32 -- requirements
Module: queue32

Interface
REQ-001 SHALL have parameter WIDTH, default 1, the data bits per entry.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_aclk_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port enq_valid, input, 1, producer offers enq_data this cycle.
REQ-005 SHALL have port enq_ready, output, 1, queue accepts an entry this cycle.
REQ-006 SHALL have port enq_data, input, WIDTH, the entry to write.
REQ-007 SHALL have port deq_valid, output, 1, the head entry is present on deq_data.
REQ-008 SHALL have port deq_ready, input, 1, consumer takes the head entry this cycle.
REQ-009 SHALL have port deq_data, output, WIDTH, the head entry, selected from 32 storage entries by the 5-bit head pointer.
REQ-010 SHALL have port count, output, 6, the number of occupied entries, 0..32.
REQ-011 SHALL have port flush, input, 1, synchronous empty request; present only when QUEUE32_FLUSH_EN is defined.

Function
REQ-012 SHALL hold 32 entries of WIDTH bits in a circular buffer, with a 5-bit head (read) pointer, a 5-bit tail (write) pointer and a 6-bit occupancy counter.
REQ-013 SHALL drive enq_ready = (count != 32) and deq_valid = (count != 0), combinationally from registered state only.
REQ-014 SHALL define enqueue as enq_valid & enq_ready: write enq_data to entry[tail] and increment tail at the clock edge.
REQ-015 SHALL define dequeue as deq_valid & deq_ready: increment head at the clock edge.
REQ-016 SHALL wrap both pointers modulo 32 (31 -> 0) with no stall or bubble.
REQ-017 SHALL update count as +1 on enqueue only, -1 on dequeue only, and unchanged on both or neither.
REQ-018 SHALL allow simultaneous enqueue and dequeue when 0 < count < 32.
REQ-019 SHALL handle the boundaries as follows:
- when full, dequeue only, since enq_ready = 0;
- when empty, enqueue only, since deq_valid = 0.
REQ-020 SHALL have enqueue-to-dequeue latency of exactly one cycle: an entry written at edge N is visible on deq_data with deq_valid = 1 after edge N; there is no combinational enq-to-deq bypass.
REQ-021 SHALL drive deq_data = entry[head] at all times, including when empty; it is stale or reset data, and consumers qualify it with deq_valid.
REQ-022 SHALL leave all state unchanged when enq_valid = 1 and enq_ready = 0, and also when deq_ready = 1 and deq_valid = 0.
REQ-023 SHALL have no combinational path from enq_valid to enq_ready, nor from deq_ready to deq_valid.

Reset
REQ-024 SHALL, while rst_aclk_n = 0, force head = 0, tail = 0, count = 0 and every storage entry = 0, immediately and independent of clk.
REQ-025 SHALL therefore present enq_ready = 1, deq_valid = 0, deq_data = 0 and count = 0 during and after reset.
REQ-026 SHALL, on reset asserted mid-operation (for example with count = 17), discard all contents, with no partial write completing.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst_aclk_n deasserts.

Configuration
REQ-028 SHALL, with QUEUE32_FLUSH_EN defined, add the flush input: flush = 1 at an edge sets head = tail = 0 and count = 0, has priority over any same-cycle enqueue and dequeue, and leaves storage contents unchanged.
REQ-029 SHALL, with QUEUE32_FLUSH_EN undefined, have no flush port and behave exactly as if flush were tied to 0.

Structure
REQ-030 SHALL take QUEUE32_DEPTH = 32, QUEUE32_PTR_W = 5 and QUEUE32_CNT_W = 6 from the shared core definitions package; no local redefinition.
REQ-031 SHALL produce deq_data by instantiating the existing 32:1 multiplexer sub-module mux32 (parameter WIDTH), with ins = storage and sel = head.
REQ-032 SHALL build the write-enable decode and the pointer/count logic in the same standard-cell gate style as the rest of the misc library.

Verification
REQ-033 SHALL cover reset: assert rst_aclk_n = 0 between clk edges with count = 5 -> count = 0, deq_valid = 0, enq_ready = 1 and deq_data = 0 immediately.
REQ-034 SHALL cover fill: enqueue 0x00..0x1F (WIDTH = 8) with deq_ready = 0 -> count = 32, enq_ready = 0, and a 33rd offer is ignored with count still 32.
REQ-035 SHALL cover drain: from full, deq_ready = 1 for 32 cycles -> deq_data sequence 0x00..0x1F in order, then deq_valid = 0 and count = 0.
REQ-036 SHALL cover wrap: 40 cycles of simultaneous enqueue and dequeue at count = 3 -> count stays 3, FIFO order holds across pointer wrap 31 -> 0.
REQ-037 SHALL cover latency: from empty, enqueue 0xA5 at edge N -> deq_valid = 1 and deq_data = 0xA5 only after edge N, and deq_valid = 0 before it.
REQ-038 SHALL cover flush (QUEUE32_FLUSH_EN defined): flush together with enq_valid and deq_ready at count = 10 -> count = 0 and deq_valid = 0 next cycle.

Source files
------------

// File: rtl/queue32_pkg.sv
// Shared queue32 core definitions: storage depth and pointer/counter widths.
package queue32_pkg;

    localparam int QUEUE32_DEPTH = 32;
    localparam int QUEUE32_PTR_W = 5;
    localparam int QUEUE32_CNT_W = 6;

    typedef logic [QUEUE32_PTR_W-1:0] q32_ptr_t;
    typedef logic [QUEUE32_CNT_W-1:0] q32_cnt_t;

endpackage

// File: rtl/queue32_mux32.sv
// 32:1 multiplexer selecting one WIDTH-bit entry from the packed input array.
module mux32
    import queue32_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [QUEUE32_DEPTH-1:0][WIDTH-1:0] ins,
    input  logic [QUEUE32_PTR_W-1:0]            sel,
    output logic [WIDTH-1:0]                    out
);

    assign out = ins[sel];

endmodule

// File: rtl/queue32.sv
// 32-entry circular-buffer FIFO with ready/valid handshakes on both sides.
// Optional synchronous flush input is enabled by defining QUEUE32_FLUSH_EN.
module queue32
    import queue32_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_aclk_n,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [WIDTH-1:0]         enq_data,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [WIDTH-1:0]         deq_data,
    output logic [QUEUE32_CNT_W-1:0] count
`ifdef QUEUE32_FLUSH_EN
    ,
    input  logic                     flush
`endif
);

    localparam q32_cnt_t FULL_CNT = q32_cnt_t'(QUEUE32_DEPTH);

    logic [QUEUE32_DEPTH-1:0][WIDTH-1:0] storage;
    logic [QUEUE32_DEPTH-1:0]            wr_en;
    q32_ptr_t                            head;
    q32_ptr_t                            tail;
    logic                                flush_req;
    logic                                do_enq;
    logic                                do_deq;

`ifdef QUEUE32_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Handshake outputs depend only on the registered count, never on enq_valid/deq_ready.
    assign enq_ready = (count != FULL_CNT);
    assign deq_valid = (count != '0);

    // A flush wins over both transfers, so neither write nor pointer movement happens.
    assign do_enq = enq_valid & enq_ready & ~flush_req;
    assign do_deq = deq_valid & deq_ready & ~flush_req;

    always_comb begin
        for (int i = 0; i < QUEUE32_DEPTH; i++) begin
            wr_en[i] = do_enq & (tail == q32_ptr_t'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_aclk_n) begin
        if (!rst_aclk_n) begin
            storage <= '0;
        end else begin
            for (int i = 0; i < QUEUE32_DEPTH; i++) begin
                if (wr_en[i]) begin
                    storage[i] <= enq_data;
                end
            end
        end
    end

    // Pointers wrap naturally at 5 bits; count tracks occupancy 0..32.
    always_ff @(posedge clk or negedge rst_aclk_n) begin
        if (!rst_aclk_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_req) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) begin
                tail <= tail + q32_ptr_t'(1);
            end
            if (do_deq) begin
                head <= head + q32_ptr_t'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + q32_cnt_t'(1);
                2'b01:   count <= count - q32_cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    mux32 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .ins(storage),
        .sel(head),
        .out(deq_data)
    );

endmodule
